prog_prefetch: RTL and testbench

PROG_PREFETCH -- requirements
Module: prog_prefetch

---
 rtl/prog_prefetch.sv | 124 ++++++++++++
 tb/tb_prog_prefetch.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_prefetch.sv
// Instruction-side prefetcher for a PicoRV32 read port: one-entry next-word buffer
// in front of program memory, with flush and discard of in-flight prefetches.
module prog_prefetch #(
   parameter logic [31:0] REGION_MASK = 32'h0010_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cpu_valid,
   input  logic [31:0] cpu_addr,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   input  logic        flush,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state,
   output logic        dbg_buf_vld,
   output logic [29:0] dbg_buf_tag
);

   // Handshakes: cpu_valid is held by the CPU until it sees the one-cycle
   // cpu_ready strobe; mem_valid is held with a stable mem_addr until the
   // one-cycle mem_ready strobe is sampled, and is only dropped early by rstn.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      PREF  = 2'd2
   } state_t;

   state_t      state;
   logic        buf_vld;
   logic [29:0] buf_tag;
   logic [31:0] buf_data;
   logic        discard;

   logic [31:0] req_addr;
   logic [31:0] pf_hit;
   logic [31:0] pf_miss;
   logic        lookup;
   logic        hit;
   logic        unused_addr_lsb;

   function automatic logic in_region(input logic [31:0] a);
      return (a & REGION_MASK) != 32'd0;
   endfunction

   assign req_addr        = {cpu_addr[31:2], 2'b00};
   assign pf_hit          = req_addr + 32'd4;
   // In FETCH, mem_addr still holds the demand address.
   assign pf_miss         = mem_addr + 32'd4;
   assign lookup          = (state == IDLE) && cpu_valid && !cpu_ready && in_region(cpu_addr);
   assign hit             = buf_vld && !flush && (buf_tag == cpu_addr[31:2]);
   assign unused_addr_lsb = ^cpu_addr[1:0];

   assign dbg_state   = state;
   assign dbg_buf_vld = buf_vld;
   assign dbg_buf_tag = buf_tag;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cpu_ready <= 1'b0;
         cpu_rdata <= 32'd0;
         mem_valid <= 1'b0;
         mem_addr  <= 32'd0;
         buf_vld   <= 1'b0;
         buf_tag   <= 30'd0;
         buf_data  <= 32'd0;
         discard   <= 1'b0;
      end else begin
         cpu_ready <= 1'b0;
         if (flush) begin
            buf_vld <= 1'b0;
            if (state == PREF) discard <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (lookup) begin
                  if (hit) begin
                     cpu_ready <= 1'b1;
                     cpu_rdata <= buf_data;
                     mem_addr  <= pf_hit;
                     discard   <= 1'b0;
                     state     <= in_region(pf_hit) ? PREF : IDLE;
                  end else begin
                     mem_valid <= 1'b1;
                     mem_addr  <= req_addr;
                     state     <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (mem_ready) begin
                  cpu_ready <= 1'b1;
                  cpu_rdata <= mem_rdata;
                  mem_valid <= 1'b0;
                  mem_addr  <= pf_miss;
                  discard   <= 1'b0;
                  state     <= in_region(pf_miss) ? PREF : IDLE;
               end
            end
            PREF: begin
               // mem_valid rises one cycle after entry so the demand strobe and
               // the prefetch request never overlap on the memory port.
               if (!mem_valid) begin
                  mem_valid <= 1'b1;
               end else if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (!discard && !flush) begin
                     buf_vld  <= 1'b1;
                     buf_tag  <= mem_addr[31:2];
                     buf_data <= mem_rdata;
                  end
                  discard <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_prefetch.sv
// Directed bench for prog_prefetch: driver tasks queue expected CPU responses and
// memory requests; monitor processes pop and compare when the DUT presents them.
module tb_prog_prefetch;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PREF = 2'd2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cpu_valid = 1'b0;
   logic [31:0] cpu_addr = 32'd0;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        flush = 1'b0;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic [1:0]  dbg_state;
   logic        dbg_buf_vld;
   logic [29:0] dbg_buf_tag;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];
   logic [31:0] mem_exp_q[$];

   bit mem_auto = 1'b1;
   bit stray = 1'b0;
   bit mem_seen = 1'b0;
   bit mon_cr_prev = 1'b0;
   bit mon_mv_prev = 1'b0;
   bit mon_mr_prev = 1'b0;

   prog_prefetch #(.REGION_MASK(32'h0010_0000)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .cpu_valid   (cpu_valid),
      .cpu_addr    (cpu_addr),
      .cpu_ready   (cpu_ready),
      .cpu_rdata   (cpu_rdata),
      .flush       (flush),
      .mem_valid   (mem_valid),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .dbg_state   (dbg_state),
      .dbg_buf_vld (dbg_buf_vld),
      .dbg_buf_tag (dbg_buf_tag)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0010_0000) ? 32'h0000_0093 : ~a;
   endfunction

   // program memory: answers one cycle after it first samples mem_valid
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            mem_ready = 1'b0;
            mem_seen  = 1'b0;
         end else if (mem_ready) begin
            mem_ready = 1'b0;
            mem_seen  = 1'b0;
         end else if (stray) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            stray     = 1'b0;
         end else if (mem_valid && mem_auto) begin
            if (mem_seen) begin
               mem_ready = 1'b1;
               mem_rdata = mem_word(mem_addr);
            end else begin
               mem_seen = 1'b1;
            end
         end
      end
   end

   // CPU response monitor
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rstn) begin
            mon_cr_prev = 1'b0;
         end else begin
            if (cpu_ready) begin
               check("cpu_ready_single_cycle", {31'd0, mon_cr_prev}, 32'd0);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_cpu_ready: got data %h expected no response", cpu_rdata);
               end else begin
                  check("cpu_rdata", cpu_rdata, exp_q.pop_front());
               end
            end
            mon_cr_prev = cpu_ready;
         end
      end
   end

   // memory request monitor
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (!rstn) begin
            mon_mv_prev = 1'b0;
            mon_mr_prev = 1'b0;
         end else begin
            if (mem_valid && !mon_mv_prev) begin
               if (mem_exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_mem_req: got addr %h expected no request", mem_addr);
               end else begin
                  check("mem_addr", mem_addr, mem_exp_q.pop_front());
               end
            end
            if (mon_mv_prev && !mem_valid)
               check("mem_valid_held_until_ready", {31'd0, mon_mr_prev}, 32'd1);
            mon_mv_prev = mem_valid;
            mon_mr_prev = mem_ready;
         end
      end
   end

   // driver: one CPU read; lat <= 0 skips the latency check
   task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input int lat,
                          input bit hold, input bit with_flush);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      exp_q.push_back(data);
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_addr  = addr;
      flush     = with_flush;
      while (!got && n < 40) begin
         @(negedge clk);
         flush = 1'b0;
         #3;
         n++;
         if (cpu_ready) got = 1'b1;
      end
      check("resp_seen", {31'd0, got}, 32'd1);
      if (got && lat > 0) check("latency", n, lat);
      if (hold) begin
         @(posedge clk);
         @(negedge clk);
      end
      cpu_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge clk);
         #3;
         n++;
         ok = (dbg_state == S_IDLE) && !mem_valid;
      end
      check("idle_reached", {31'd0, ok}, 32'd1);
   endtask

   task automatic flush_on_pref_ready();
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      while (!done && n < 20) begin
         @(negedge clk);
         #1;
         n++;
         if (mem_ready && mem_valid && dbg_state == S_PREF) begin
            flush = 1'b1;
            done  = 1'b1;
            @(negedge clk);
            flush = 1'b0;
         end
      end
      check("flush_race_aligned", {31'd0, done}, 32'd1);
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected end of test");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int cr_cnt;
      int mv_cnt;
      int busy_cnt;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      @(negedge clk);
      #1 rstn = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_buf_vld", {31'd0, dbg_buf_vld}, 32'd0);
      check("rst_buf_tag", {2'd0, dbg_buf_tag}, 32'd0);

      // cold miss then prefetch of the next word
      mem_exp_q.push_back(32'h0010_0000);
      mem_exp_q.push_back(32'h0010_0004);
      do_read(32'h0010_0000, 32'h0000_0093, 3, 1'b0, 1'b0);
      wait_idle();
      check("cold_buf_vld", {31'd0, dbg_buf_vld}, 32'd1);
      check("cold_buf_tag", {2'd0, dbg_buf_tag}, 32'h0004_0001);

      // sequential hit
      mem_exp_q.push_back(32'h0010_0008);
      do_read(32'h0010_0004, 32'hFFEF_FFFB, 1, 1'b0, 1'b0);
      wait_idle();
      check("seq_buf_tag", {2'd0, dbg_buf_tag}, 32'h0004_0002);

      // non-sequential miss; flush lands on the prefetch's mem_ready
      mem_exp_q.push_back(32'h0010_0040);
      mem_exp_q.push_back(32'h0010_0044);
      do_read(32'h0010_0040, 32'hFFEF_FFBF, 3, 1'b0, 1'b0);
      flush_on_pref_ready();
      wait_idle();
      check("flush_race_buf_vld", {31'd0, dbg_buf_vld}, 32'd0);

      // prefetched word was discarded, so this misses
      mem_exp_q.push_back(32'h0010_0044);
      mem_exp_q.push_back(32'h0010_0048);
      do_read(32'h0010_0044, 32'hFFEF_FFBB, 3, 1'b0, 1'b0);
      wait_idle();
      check("refill_buf_vld", {31'd0, dbg_buf_vld}, 32'd1);

      // flush coinciding with a lookup that would hit turns it into a miss
      mem_exp_q.push_back(32'h0010_0048);
      mem_exp_q.push_back(32'h0010_004C);
      do_read(32'h0010_0048, 32'hFFEF_FFB7, 3, 1'b0, 1'b1);
      wait_idle();

      // region edge: next word leaves the region, no prefetch
      mem_exp_q.push_back(32'h001F_FFFC);
      do_read(32'h001F_FFFC, 32'hFFE0_0003, 3, 1'b0, 1'b0);
      @(negedge clk);
      #3;
      check("edge_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      check("edge_mem_valid", {31'd0, mem_valid}, 32'd0);

      // cpu_valid still high during the cpu_ready cycle must not be re-accepted
      mem_exp_q.push_back(32'h001F_FFFC);
      do_read(32'h001F_FFFC, 32'hFFE0_0003, 3, 1'b1, 1'b0);
      repeat (4) @(negedge clk);

      // out-of-region request is ignored
      cr_cnt = 0;
      mv_cnt = 0;
      busy_cnt = 0;
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_addr  = 32'h0000_1000;
      repeat (8) begin
         @(negedge clk);
         #3;
         if (cpu_ready) cr_cnt++;
         if (mem_valid) mv_cnt++;
         if (dbg_state != S_IDLE) busy_cnt++;
      end
      cpu_valid = 1'b0;
      check("ignore_cpu_ready", cr_cnt, 32'd0);
      check("ignore_mem_valid", mv_cnt, 32'd0);
      check("ignore_state", busy_cnt, 32'd0);

      // hit with nonzero low address bits, then a request stalled behind PREF
      mem_exp_q.push_back(32'h0010_0050);
      do_read(32'h0010_004E, 32'hFFEF_FFB3, 1, 1'b0, 1'b0);
      mem_exp_q.push_back(32'h0010_0054);
      do_read(32'h0010_0050, 32'hFFEF_FFAF, 0, 1'b0, 1'b0);
      wait_idle();

      // reset while a prefetch is outstanding
      mem_auto = 1'b0;
      mem_exp_q.push_back(32'h0010_0058);
      do_read(32'h0010_0054, 32'hFFEF_FFAB, 1, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      #3;
      check("pref_mem_valid_held", {31'd0, mem_valid}, 32'd1);
      check("pref_mem_addr", mem_addr, 32'h0010_0058);
      @(negedge clk);
      #1 rstn = 1'b0;
      #1;
      check("async_rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      check("async_rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      check("async_rst_buf_vld", {31'd0, dbg_buf_vld}, 32'd0);
      check("async_rst_mem_addr", mem_addr, 32'd0);
      repeat (2) @(negedge clk);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1 stray = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      check("stray_buf_vld", {31'd0, dbg_buf_vld}, 32'd0);
      check("stray_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      check("stray_mem_valid", {31'd0, mem_valid}, 32'd0);
      mem_auto = 1'b1;

      // buffer was cleared by reset
      mem_exp_q.push_back(32'h0010_0058);
      mem_exp_q.push_back(32'h0010_005C);
      do_read(32'h0010_0058, 32'hFFEF_FFA7, 3, 1'b0, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);

      check("resp_queue_drained", exp_q.size(), 32'd0);
      check("mem_queue_drained", mem_exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
